// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/Counter.sv
// Up-counter with synchronous clear that wraps to zero after reaching MAX.
module Counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == MAX) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ShiftRegister_PISO.sv
// Parallel-in serial-out shifter: parallel load, right shift, serial out is bit 0.
module ShiftRegister_PISO #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             serial,
  output logic             serial_next
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign serial      = q[0];
  // Bit that appears on serial after the next shift, so tx can be registered.
  assign serial_next = q[1];

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with a one-entry holding register for back-to-back frames.
module uart_transmit
  import uart_pkg::*;
#(
  parameter int CLK_SPEED = 5_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dataIn,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       finished_send,
  output logic       busy
);

  localparam int BAUD_TICK       = CLK_SPEED / BAUD_RATE;
  localparam int BAUD_TICK_WIDTH = $clog2(BAUD_TICK + 1);
  localparam int BIT_WIDTH       = $clog2(DATA_BITS);

  tx_state_t                  state;
  logic                       hold_valid;
  logic [7:0]                 hold;
  logic [BAUD_TICK_WIDTH-1:0] baud_count;
  logic [BIT_WIDTH-1:0]       bit_count;
  logic                       baud_run;
  logic                       baud_end;
  logic                       bit_last;
  logic                       load;
  logic                       shift;
  logic                       serial;
  logic                       serial_next;
  logic                       stop_last_next;

  assign ready    = ~hold_valid;
  assign busy     = (state != IDLE);
  assign baud_run = (state != IDLE);
  assign baud_end = baud_run && (baud_count == BAUD_TICK_WIDTH'(BAUD_TICK - 1));
  assign bit_last = (bit_count == BIT_WIDTH'(DATA_BITS - 1));
  assign load     = hold_valid && ((state == IDLE) || ((state == STOP) && baud_end));
  assign shift    = (state == DATA) && baud_end;

  // finished_send is registered, so flag the edge that enters the last stop cycle.
  assign stop_last_next = ((state == STOP) && !baud_end && (int'(baud_count) == BAUD_TICK - 2))
                       || (shift && bit_last && (BAUD_TICK == 1));

  Counter #(
    .WIDTH (BAUD_TICK_WIDTH),
    .MAX   (BAUD_TICK_WIDTH'(BAUD_TICK - 1))
  ) u_baud_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (~baud_run),
    .enable (baud_run),
    .count  (baud_count)
  );

  Counter #(
    .WIDTH (BIT_WIDTH),
    .MAX   (BIT_WIDTH'(DATA_BITS - 1))
  ) u_bit_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != DATA),
    .enable (shift),
    .count  (bit_count)
  );

  ShiftRegister_PISO #(
    .WIDTH (DATA_BITS)
  ) u_shifter (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .shift       (shift),
    .d           (hold),
    .serial      (serial),
    .serial_next (serial_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      tx            <= 1'b1;
      hold_valid    <= 1'b0;
      hold          <= '0;
      finished_send <= 1'b0;
    end else begin
      finished_send <= stop_last_next;
      if (send && ready) begin
        hold       <= dataIn;
        hold_valid <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (hold_valid) begin
            state      <= START;
            tx         <= 1'b0;
            hold_valid <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state <= DATA;
            tx    <= serial;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_last) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx <= serial_next;
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            if (hold_valid) begin
              state      <= START;
              tx         <= 1'b0;
              hold_valid <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
